// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - in-order commit stage with retirement RAT, mispredict flush and RAT restore
module commit_unit #(
  parameter int PR_BITS      = 6,
  parameter int ROBSIZE_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ROBSIZE_BITS:0]   rob_elemcount,
  input  logic                    rob_head_ready,
  input  logic                    rob_head_regf_we,
  input  logic [4:0]              rob_head_rd,
  input  logic [PR_BITS-1:0]      rob_head_pd,
  input  logic                    rob_head_mispredict,
  input  logic [31:0]             rob_head_target,
  output logic                    rob_dequeue,
  input  logic                    fl_full,
  output logic                    fl_enqueue,
  output logic [PR_BITS-1:0]      fl_din,
  output logic                    flush,
  output logic                    redirect_valid,
  output logic [31:0]             redirect_pc,
  output logic                    rat_restore_we,
  output logic [4:0]              rat_restore_addr,
  output logic [PR_BITS-1:0]      rat_restore_pd,
  output logic                    busy,
  output logic [31:0]             retire_count
);

  typedef enum logic [1:0] {IDLE, FLUSH, RESTORE} state_t;

  state_t             state;
  logic [PR_BITS-1:0] rrat [32];
  logic [4:0]         restore_idx;
  logic [31:0]        target_q;
  logic [31:0]        retire_q;
  logic               wr;
  logic               commit;

  // Commit decision: ROB is only looked at while idle; a write that the free
  // list cannot absorb stalls the head. Outputs are gated by rst_n so they
  // read as zero for the whole reset interval.
  always_comb begin
    wr     = rob_head_regf_we && (rob_head_rd != 5'd0);
    commit = rst_n && (state == IDLE) && (rob_elemcount != '0) &&
             rob_head_ready && !(wr && fl_full);
  end

  // Output decode from current state and inputs
  always_comb begin
    rob_dequeue      = commit;
    fl_enqueue       = commit && wr;
    fl_din           = '0;
    flush            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'd0;
    rat_restore_we   = 1'b0;
    rat_restore_addr = 5'd0;
    rat_restore_pd   = '0;
    busy             = 1'b0;
    retire_count     = rst_n ? retire_q : 32'd0;
    if (commit && wr) begin
      fl_din = rrat[rob_head_rd];
    end
    if (rst_n && state == FLUSH) begin
      flush          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = target_q;
      busy           = 1'b1;
    end
    if (rst_n && state == RESTORE) begin
      rat_restore_we   = 1'b1;
      rat_restore_addr = restore_idx;
      rat_restore_pd   = rrat[restore_idx];
      busy             = 1'b1;
    end
  end

  // State machine, RRAT update, retire counter and restore walk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      restore_idx <= 5'd0;
      target_q    <= 32'd0;
      retire_q    <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        rrat[i] <= PR_BITS'(i);
      end
    end else begin
      case (state)
        IDLE: begin
          if (commit) begin
            retire_q <= retire_q + 32'd1;
            if (wr) begin
              rrat[rob_head_rd] <= rob_head_pd;
            end
            if (rob_head_mispredict) begin
              target_q <= rob_head_target;
              state    <= FLUSH;
            end
          end
        end
        FLUSH: begin
          restore_idx <= 5'd0;
          state       <= RESTORE;
        end
        RESTORE: begin
          restore_idx <= restore_idx + 5'd1;
          if (restore_idx == 5'd31) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// tb/tb_commit_unit.sv - directed scoreboard bench for commit_unit
module tb_commit_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rob_elemcount;
  logic        rob_head_ready, rob_head_regf_we, rob_head_mispredict;
  logic [4:0]  rob_head_rd;
  logic [5:0]  rob_head_pd;
  logic [31:0] rob_head_target;
  logic        rob_dequeue, fl_full, fl_enqueue;
  logic [5:0]  fl_din;
  logic        flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic        rat_restore_we;
  logic [4:0]  rat_restore_addr;
  logic [5:0]  rat_restore_pd;
  logic        busy;
  logic [31:0] retire_count;

  int total = 0;
  int bad   = 0;

  logic [5:0]  rrat_m [32];
  logic [31:0] cnt_m;
  logic [5:0]  fl_q [$];
  logic [4:0]  ra_q [$];
  logic [5:0]  rp_q [$];
  int          busy_cycles;

  commit_unit #(.PR_BITS(6), .ROBSIZE_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rob_elemcount(rob_elemcount), .rob_head_ready(rob_head_ready),
    .rob_head_regf_we(rob_head_regf_we), .rob_head_rd(rob_head_rd),
    .rob_head_pd(rob_head_pd), .rob_head_mispredict(rob_head_mispredict),
    .rob_head_target(rob_head_target), .rob_dequeue(rob_dequeue),
    .fl_full(fl_full), .fl_enqueue(fl_enqueue), .fl_din(fl_din),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rat_restore_we(rat_restore_we), .rat_restore_addr(rat_restore_addr),
    .rat_restore_pd(rat_restore_pd), .busy(busy), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rrat_m[i] = 6'(i);
    cnt_m = 32'd0;
  endtask

  task automatic push_restore();
    for (int i = 0; i < 32; i++) begin
      ra_q.push_back(5'(i));
      rp_q.push_back(rrat_m[i]);
    end
  endtask

  task automatic set_head(input logic ready, input logic we, input logic [4:0] rd,
                          input logic [5:0] pd, input logic mp, input logic [31:0] tgt);
    rob_elemcount       = 5'd2;
    rob_head_ready      = ready;
    rob_head_regf_we    = we;
    rob_head_rd         = rd;
    rob_head_pd         = pd;
    rob_head_mispredict = mp;
    rob_head_target     = tgt;
  endtask

  // Called just after a negedge with head inputs set: checks the commit outputs.
  task automatic check_commit(input string tag, input logic exp_deq, input logic exp_fl);
    chk({tag, "_deq"}, 64'(rob_dequeue), 64'(exp_deq));
    chk({tag, "_fl_enq"}, 64'(fl_enqueue), 64'(exp_fl));
    if (fl_enqueue === 1'b1) begin
      if (fl_q.size() == 0) chk({tag, "_fl_unexpected"}, 64'(fl_enqueue), 64'd0);
      else chk({tag, "_fl_din"}, 64'(fl_din), 64'(fl_q.pop_front()));
    end
  endtask

  task automatic commit_one(input string tag, input logic we, input logic [4:0] rd,
                            input logic [5:0] pd);
    set_head(1'b1, we, rd, pd, 1'b0, 32'd0);
    if (we && rd != 0) begin
      fl_q.push_back(rrat_m[rd]);
      rrat_m[rd] = pd;
    end
    cnt_m = cnt_m + 32'd1;
    #1 check_commit(tag, 1'b1, we && rd != 0);
    @(negedge clk);
    rob_head_ready = 1'b0;
    #1 chk({tag, "_retire"}, 64'(retire_count), 64'(cnt_m));
  endtask

  task automatic check_restore_step(input string tag);
    chk({tag, "_we"}, 64'(rat_restore_we), 64'd1);
    chk({tag, "_deq_stall"}, 64'(rob_dequeue), 64'd0);
    if (busy === 1'b1) busy_cycles++;
    if (ra_q.size() == 0) chk({tag, "_q_empty"}, 64'(ra_q.size()), 64'd1);
    else begin
      chk({tag, "_addr"}, 64'(rat_restore_addr), 64'(ra_q.pop_front()));
      chk({tag, "_pd"}, 64'(rat_restore_pd), 64'(rp_q.pop_front()));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_deq"}, 64'(rob_dequeue), 64'd0);
    chk({tag, "_fl_enq"}, 64'(fl_enqueue), 64'd0);
    chk({tag, "_flush"}, 64'(flush), 64'd0);
    chk({tag, "_rv"}, 64'(redirect_valid), 64'd0);
    chk({tag, "_rwe"}, 64'(rat_restore_we), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_retire"}, 64'(retire_count), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    fl_full = 1'b0;
    set_head(1'b1, 1'b1, 5'd5, 6'd40, 1'b0, 32'd0);
    model_reset();
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic commit then back-to-back commit to the same rd
    commit_one("c1", 1'b1, 5'd5, 6'd40);
    commit_one("c2", 1'b1, 5'd5, 6'd41);

    // rd=0 ignores fl_full and never releases a register
    fl_full = 1'b1;
    commit_one("rd0", 1'b1, 5'd0, 6'd12);

    // rd=3 with fl_full stalls until the free list drains
    set_head(1'b1, 1'b1, 5'd3, 6'd33, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1 check_commit("stall", 1'b0, 1'b0);
      @(negedge clk);
      #1 chk("stall_retire", 64'(retire_count), 64'(cnt_m));
    end
    fl_full = 1'b0;
    commit_one("unstall", 1'b1, 5'd3, 6'd33);

    // Empty ROB and not-ready head never commit
    set_head(1'b1, 1'b1, 5'd4, 6'd20, 1'b0, 32'd0);
    rob_elemcount = 5'd0;
    #1 check_commit("empty", 1'b0, 1'b0);
    @(negedge clk);
    set_head(1'b0, 1'b1, 5'd4, 6'd20, 1'b0, 32'd0);
    #1 check_commit("notready", 1'b0, 1'b0);
    @(negedge clk);

    // Random commits to populate the RRAT
    for (int i = 0; i < 8; i++) begin
      commit_one("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 6'($urandom_range(32, 63)));
    end

    // Mispredict with a register write: flush, 32 restores, then idle
    set_head(1'b1, 1'b1, 5'd7, 6'd50, 1'b1, 32'h6000_0100);
    fl_q.push_back(rrat_m[7]);
    rrat_m[7] = 6'd50;
    cnt_m = cnt_m + 32'd1;
    push_restore();
    #1 check_commit("mp", 1'b1, 1'b1);
    chk("mp_noflush", 64'(flush), 64'd0);
    @(negedge clk);
    set_head(1'b1, 1'b0, 5'd9, 6'd9, 1'b0, 32'd0);
    busy_cycles = 0;
    #1;
    chk("fl_flush", 64'(flush), 64'd1);
    chk("fl_rv", 64'(redirect_valid), 64'd1);
    chk("fl_pc", 64'(redirect_pc), 64'h6000_0100);
    chk("fl_deq", 64'(rob_dequeue), 64'd0);
    chk("fl_rwe", 64'(rat_restore_we), 64'd0);
    chk("fl_retire", 64'(retire_count), 64'(cnt_m));
    if (busy === 1'b1) busy_cycles++;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      #1 check_restore_step("rs");
      chk("rs_flush", 64'(flush), 64'd0);
    end
    @(negedge clk);
    cnt_m = cnt_m + 32'd1;
    #1;
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_rwe", 64'(rat_restore_we), 64'd0);
    chk("post_deq", 64'(rob_dequeue), 64'd1);
    chk("busy_cycles", 64'(busy_cycles), 64'd33);
    chk("rs_q_drained", 64'(ra_q.size()), 64'd0);
    @(negedge clk);
    rob_head_ready = 1'b0;
    #1 chk("post_retire", 64'(retire_count), 64'(cnt_m));

    // Mispredict, then reset in the middle of the restore walk
    set_head(1'b1, 1'b0, 5'd0, 6'd0, 1'b1, 32'h0000_1234);
    cnt_m = cnt_m + 32'd1;
    push_restore();
    #1 check_commit("mp2", 1'b1, 1'b0);
    @(negedge clk);
    set_head(1'b1, 1'b0, 5'd0, 6'd0, 1'b0, 32'd0);
    #1 chk("fl2_pc", 64'(redirect_pc), 64'h0000_1234);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      #1 check_restore_step("rs2");
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort");
    ra_q.delete();
    rp_q.delete();
    model_reset();
    @(negedge clk);
    rob_head_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check_all_zero("after_abort");
    end

    // Restore after reset must replay the identity mapping
    set_head(1'b1, 1'b0, 5'd0, 6'd0, 1'b1, 32'h0000_0040);
    cnt_m = cnt_m + 32'd1;
    push_restore();
    #1 check_commit("mp3", 1'b1, 1'b0);
    @(negedge clk);
    rob_head_ready = 1'b0;
    rob_head_mispredict = 1'b0;
    #1 chk("fl3_flush", 64'(flush), 64'd1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      #1 check_restore_step("rs3");
    end
    @(negedge clk);
    #1;
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_retire", 64'(retire_count), 64'(cnt_m));
    chk("end_fl_q", 64'(fl_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
